// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and types for the decode stage and its register file.
package y86_pkg;

    localparam int WORD = 64;
    localparam int NREG = 15;

    // Register IDs with a fixed meaning
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // One-hot status encodings {AOK,HLT,ADR,INS}
    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    // Contents of the E pipeline register
    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [WORD-1:0] valC;
        logic [WORD-1:0] valA;
        logic [WORD-1:0] valB;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
        logic [3:0]      srcA;
        logic [3:0]      srcB;
    } e_reg_t;

    // A nop that carries no register traffic
    localparam e_reg_t E_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        valC:  '0,
        valA:  '0,
        valB:  '0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: 15 words, two combinational reads, two
// posedge writes (port M beats port E on the same ID), async clear.
module y86_regfile
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      i_srcA,
    input  logic [3:0]      i_srcB,
    input  logic [3:0]      i_dstE,
    input  logic [WORD-1:0] i_valE,
    input  logic [3:0]      i_dstM,
    input  logic [WORD-1:0] i_valM,
    output logic [WORD-1:0] o_valA,
    output logic [WORD-1:0] o_valB
);

    // Entry 15 (RNONE) is a constant zero so reads of "no register" are defined
    logic [WORD-1:0] w_regs [0:15];

    assign w_regs[15] = '0;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [3:0] ID = 4'(gi);
            logic [WORD-1:0] r_q;

            // Per-register write; port M takes precedence over port E
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (i_dstM == ID) begin
                    r_q <= i_valM;
                end else if (i_dstE == ID) begin
                    r_q <= i_valE;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign o_valA = w_regs[i_srcA];
    assign o_valB = w_regs[i_srcB];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode/writeback stage: field decode, register-file read with
// E/M/W forwarding, and the E pipeline register.
module decode_stage
    import y86_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      D_stat,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [3:0]      D_rA,
    input  logic [3:0]      D_rB,
    input  logic [WORD-1:0] D_valC,
    input  logic [WORD-1:0] D_valP,
    input  logic            E_bubble,
    input  logic [3:0]      e_dstE,
    input  logic [WORD-1:0] e_valE,
    input  logic [3:0]      M_dstE,
    input  logic [WORD-1:0] M_valE,
    input  logic [3:0]      M_dstM,
    input  logic [WORD-1:0] m_valM,
    input  logic [3:0]      W_dstE,
    input  logic [WORD-1:0] W_valE,
    input  logic [3:0]      W_dstM,
    input  logic [WORD-1:0] W_valM,
    output logic [3:0]      d_srcA,
    output logic [3:0]      d_srcB,
    output logic [3:0]      E_stat,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [WORD-1:0] E_valC,
    output logic [WORD-1:0] E_valA,
    output logic [WORD-1:0] E_valB,
    output logic [3:0]      E_dstE,
    output logic [3:0]      E_dstM,
    output logic [3:0]      E_srcA,
    output logic [3:0]      E_srcB
);

    logic [3:0]      w_srcA, w_srcB, w_dstE, w_dstM;
    logic [WORD-1:0] w_rvalA, w_rvalB;
    logic [WORD-1:0] w_valA, w_valB;
    e_reg_t          w_e_next;
    e_reg_t          r_e;

    // Forwarding priority: e.valE, m.valM, M.valE, W.valM, W.valE, then regfile.
    // RNONE never matches, so an unused source falls through to the regfile's zero.
    function automatic logic [WORD-1:0] fwd(
        input logic [3:0]      src,
        input logic [WORD-1:0] rf_val,
        input logic [3:0]      e_dE,  input logic [WORD-1:0] e_vE,
        input logic [3:0]      m_dM,  input logic [WORD-1:0] m_vM,
        input logic [3:0]      m_dE,  input logic [WORD-1:0] m_vE,
        input logic [3:0]      w_dM,  input logic [WORD-1:0] w_vM,
        input logic [3:0]      w_dE,  input logic [WORD-1:0] w_vE
    );
        logic [WORD-1:0] v;
        v = rf_val;
        if (src != RNONE) begin
            if      (src == e_dE) v = e_vE;
            else if (src == m_dM) v = m_vM;
            else if (src == m_dE) v = m_vE;
            else if (src == w_dM) v = w_vM;
            else if (src == w_dE) v = w_vE;
        end
        return v;
    endfunction

    // Register-ID decode from icode; cmov resolves its condition later, so
    // icode 2 always names rB as its destination here
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ: begin w_srcA = D_rA;                  w_dstE = D_rB; end
            I_IRMOVQ: begin                                 w_dstE = D_rB; end
            I_RMMOVQ: begin w_srcA = D_rA; w_srcB = D_rB;                  end
            I_MRMOVQ: begin                w_srcB = D_rB;  w_dstM = D_rA; end
            I_OPQ:    begin w_srcA = D_rA; w_srcB = D_rB;  w_dstE = D_rB; end
            I_CALL:   begin                w_srcB = RRSP;  w_dstE = RRSP; end
            I_RET:    begin w_srcA = RRSP; w_srcB = RRSP;  w_dstE = RRSP; end
            I_PUSHQ:  begin w_srcA = D_rA; w_srcB = RRSP;  w_dstE = RRSP; end
            I_POPQ:   begin w_srcA = RRSP; w_srcB = RRSP;  w_dstE = RRSP;
                            w_dstM = D_rA; end
            default:  ;
        endcase
    end

    assign d_srcA = w_srcA;
    assign d_srcB = w_srcB;

    y86_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_srcA (w_srcA),
        .i_srcB (w_srcB),
        .i_dstE (W_dstE),
        .i_valE (W_valE),
        .i_dstM (W_dstM),
        .i_valM (W_valM),
        .o_valA (w_rvalA),
        .o_valB (w_rvalB)
    );

    // valA/valB selection; jXX and call carry valP down the pipe in valA
    always_comb begin
        w_valA = fwd(w_srcA, w_rvalA, e_dstE, e_valE, M_dstM, m_valM,
                     M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        if (D_icode == I_JXX || D_icode == I_CALL) begin
            w_valA = D_valP;
        end
        w_valB = fwd(w_srcB, w_rvalB, e_dstE, e_valE, M_dstM, m_valM,
                     M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    end

    // Next E contents: the decoded instruction, or a nop bubble
    always_comb begin
        w_e_next = E_BUBBLE;
        if (!E_bubble) begin
            w_e_next.stat  = D_stat;
            w_e_next.icode = D_icode;
            w_e_next.ifun  = D_ifun;
            w_e_next.valC  = D_valC;
            w_e_next.valA  = w_valA;
            w_e_next.valB  = w_valB;
            w_e_next.dstE  = w_dstE;
            w_e_next.dstM  = w_dstM;
            w_e_next.srcA  = w_srcA;
            w_e_next.srcB  = w_srcB;
        end
    end

    // E pipeline register; never stalls, reset loads a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e <= E_BUBBLE;
        end else begin
            r_e <= w_e_next;
        end
    end

    assign E_stat  = r_e.stat;
    assign E_icode = r_e.icode;
    assign E_ifun  = r_e.ifun;
    assign E_valC  = r_e.valC;
    assign E_valA  = r_e.valA;
    assign E_valB  = r_e.valB;
    assign E_dstE  = r_e.dstE;
    assign E_dstM  = r_e.dstM;
    assign E_srcA  = r_e.srcA;
    assign E_srcB  = r_e.srcB;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus hand sequences for
// reset, writeback, forwarding priority and write-port collision.
module tb_decode_stage;

    localparam logic [3:0] F   = 4'hF;
    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] HLT = 4'b0100;
    localparam logic [3:0] INS = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  D_stat = AOK, D_icode = 4'h1, D_ifun = 4'h0, D_rA = F, D_rB = F;
    logic [63:0] D_valC = '0, D_valP = '0;
    logic        E_bubble = 1'b0;
    logic [3:0]  e_dstE = F, M_dstE = F, M_dstM = F, W_dstE = F, W_dstM = F;
    logic [63:0] e_valE = '0, M_valE = '0, m_valM = '0, W_valE = '0, W_valM = '0;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    typedef struct {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  stat, icode, ifun, rA, rB;
        logic [63:0] valC, valP;
        logic        bubble;
        exp_t        exp;
    } vec_t;

    exp_t scoreboard[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one D instruction at the negedge, check the combinational source
    // IDs, then pop the expectation once the E register has captured it
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        D_stat = v.stat; D_icode = v.icode; D_ifun = v.ifun; D_rA = v.rA; D_rB = v.rB;
        D_valC = v.valC; D_valP = v.valP; E_bubble = v.bubble;
        scoreboard.push_back(v.exp);
        #1;
        if (!v.bubble) begin
            chk({v.name, ".d_srcA"}, 64'(d_srcA), 64'(v.exp.srcA));
            chk({v.name, ".d_srcB"}, 64'(d_srcB), 64'(v.exp.srcB));
        end
        @(posedge clk);
        #1;
        e = scoreboard.pop_front();
        chk({v.name, ".stat"},  64'(E_stat),  64'(e.stat));
        chk({v.name, ".icode"}, 64'(E_icode), 64'(e.icode));
        chk({v.name, ".ifun"},  64'(E_ifun),  64'(e.ifun));
        chk({v.name, ".valC"},  E_valC,       e.valC);
        chk({v.name, ".valA"},  E_valA,       e.valA);
        chk({v.name, ".valB"},  E_valB,       e.valB);
        chk({v.name, ".dstE"},  64'(E_dstE),  64'(e.dstE));
        chk({v.name, ".dstM"},  64'(E_dstM),  64'(e.dstM));
        chk({v.name, ".srcA"},  64'(E_srcA),  64'(e.srcA));
        chk({v.name, ".srcB"},  64'(E_srcB),  64'(e.srcB));
        $display("[TB] %s: icode=%0h valA=%0h valB=%0h dstE=%0h dstM=%0h",
                 v.name, E_icode, E_valA, E_valB, E_dstE, E_dstM);
        E_bubble = 1'b0;
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] stat, icode, ifun, rA, rB,
                                input logic [63:0] valC, valP, input logic bubble,
                                input logic [63:0] xA, xB,
                                input logic [3:0] xdE, xdM, xsA, xsB);
        vec_t v;
        v.name = name; v.stat = stat; v.icode = icode; v.ifun = ifun; v.rA = rA; v.rB = rB;
        v.valC = valC; v.valP = valP; v.bubble = bubble;
        if (bubble) begin
            v.exp = '{stat: AOK, icode: 4'h1, ifun: 4'h0, valC: 64'h0, valA: 64'h0,
                      valB: 64'h0, dstE: F, dstM: F, srcA: F, srcB: F};
        end else begin
            v.exp = '{stat: stat, icode: icode, ifun: ifun, valC: valC, valA: xA,
                      valB: xB, dstE: xdE, dstM: xdM, srcA: xsA, srcB: xsB};
        end
        return v;
    endfunction

    vec_t tbl[$];
    vec_t v;

    initial begin
        // Decode table; registers hold 0x100+i after the preload below
        tbl.push_back(mk("irmovq", AOK, 4'h3, 4'h0, F,    4'h2, 64'h55, 64'h0, 0, 64'h0,    64'h0,    4'h2, F,    F,    F));
        tbl.push_back(mk("cmovq",  AOK, 4'h2, 4'h3, 4'h1, 4'h9, 64'h0,  64'h0, 0, 64'h101,  64'h0,    4'h9, F,    4'h1, F));
        tbl.push_back(mk("rmmovq", AOK, 4'h4, 4'h0, 4'h3, 4'h5, 64'h8,  64'h0, 0, 64'h103,  64'h105,  F,    F,    4'h3, 4'h5));
        tbl.push_back(mk("mrmovq", AOK, 4'h5, 4'h0, 4'h8, 4'hA, 64'h10, 64'h0, 0, 64'h0,    64'h10A,  F,    4'h8, F,    4'hA));
        tbl.push_back(mk("opq",    AOK, 4'h6, 4'h1, 4'h0, 4'hE, 64'h0,  64'h0, 0, 64'h100,  64'h10E,  4'hE, F,    4'h0, 4'hE));
        tbl.push_back(mk("jxx",    AOK, 4'h7, 4'h2, F,    F,    64'h40, 64'h1234, 0, 64'h1234, 64'h0, F,    F,    F,    F));
        tbl.push_back(mk("call",   AOK, 4'h8, 4'h0, F,    F,    64'h40, 64'h1D, 0, 64'h1D,   64'h104,  4'h4, F,    F,    4'h4));
        tbl.push_back(mk("ret",    AOK, 4'h9, 4'h0, F,    F,    64'h0,  64'h0, 0, 64'h104,  64'h104,  4'h4, F,    4'h4, 4'h4));
        tbl.push_back(mk("pushq",  AOK, 4'hA, 4'h0, 4'h6, F,    64'h0,  64'h0, 0, 64'h106,  64'h104,  4'h4, F,    4'h6, 4'h4));
        tbl.push_back(mk("popq",   AOK, 4'hB, 4'h0, 4'hB, F,    64'h0,  64'h0, 0, 64'h104,  64'h104,  4'h4, 4'hB, 4'h4, 4'h4));
        tbl.push_back(mk("ins",    INS, 4'hC, 4'h7, 4'h3, 4'h3, 64'h77, 64'h0, 0, 64'h0,    64'h0,    F,    F,    F,    F));
        tbl.push_back(mk("halt",   HLT, 4'h0, 4'h0, 4'h2, 4'h2, 64'h0,  64'h0, 0, 64'h0,    64'h0,    F,    F,    F,    F));
        tbl.push_back(mk("bubble", AOK, 4'h3, 4'h0, F,    4'h2, 64'h99, 64'h0, 1, 64'h0,    64'h0,    F,    F,    F,    F));
        tbl.push_back(mk("nop",    AOK, 4'h1, 4'h0, F,    F,    64'h0,  64'h0, 0, 64'h0,    64'h0,    F,    F,    F,    F));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Put a real instruction in E, then reset mid-cycle
        apply(mk("pre_rst", AOK, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h0, 0, 64'h0, 64'h0, 4'h2, F, 4'h1, 4'h2));
        #2 rst_n = 1'b0;
        #1;
        chk("rst.icode", 64'(E_icode), 64'h1);
        chk("rst.stat",  64'(E_stat),  64'(AOK));
        chk("rst.dstE",  64'(E_dstE),  64'(F));
        chk("rst.dstM",  64'(E_dstM),  64'(F));
        @(negedge clk);
        rst_n = 1'b1;

        // Writeback then read
        W_dstE = 4'h7; W_valE = 64'h10;
        apply(mk("wb_nop", AOK, 4'h1, 4'h0, F, F, 64'h0, 64'h0, 0, 64'h0, 64'h0, F, F, F, F));
        W_dstE = F;
        apply(mk("wb_read", AOK, 4'h6, 4'h0, 4'h7, 4'h6, 64'h0, 64'h0, 0, 64'h10, 64'h0, 4'h6, F, 4'h7, 4'h6));

        // Preload r_i = 0x100+i, two registers per cycle
        for (int i = 0; i < 15; i += 2) begin
            W_dstE = 4'(i);     W_valE = 64'h100 + 64'(i);
            W_dstM = (i + 1 < 15) ? 4'(i + 1) : F; W_valM = 64'h100 + 64'(i + 1);
            apply(mk("preload", AOK, 4'h1, 4'h0, F, F, 64'h0, 64'h0, 0, 64'h0, 64'h0, F, F, F, F));
        end
        W_dstE = F; W_dstM = F;

        foreach (tbl[i]) apply(tbl[i]);

        // Forwarding priority on pushq rA=4 (srcA=srcB=4)
        e_dstE = 4'h4; e_valE = 64'h1;
        M_dstM = 4'h4; m_valM = 64'h2;
        W_dstE = 4'h4; W_valE = 64'h3;
        apply(mk("fwd_e", AOK, 4'hA, 4'h0, 4'h4, F, 64'h0, 64'h0, 0, 64'h1, 64'h1, 4'h4, F, 4'h4, 4'h4));
        e_dstE = F;
        apply(mk("fwd_mM", AOK, 4'hA, 4'h0, 4'h4, F, 64'h0, 64'h0, 0, 64'h2, 64'h2, 4'h4, F, 4'h4, 4'h4));
        M_dstM = F; M_dstE = 4'h4; M_valE = 64'h44;
        apply(mk("fwd_ME", AOK, 4'hA, 4'h0, 4'h4, F, 64'h0, 64'h0, 0, 64'h44, 64'h44, 4'h4, F, 4'h4, 4'h4));
        M_dstE = F; W_dstM = 4'h4; W_valM = 64'h55;
        apply(mk("fwd_WM", AOK, 4'hA, 4'h0, 4'h4, F, 64'h0, 64'h0, 0, 64'h55, 64'h55, 4'h4, F, 4'h4, 4'h4));
        W_dstM = F;
        apply(mk("fwd_WE", AOK, 4'hA, 4'h0, 4'h4, F, 64'h0, 64'h0, 0, 64'h3, 64'h3, 4'h4, F, 4'h4, 4'h4));
        W_dstE = F;
        apply(mk("rf_r4", AOK, 4'hA, 4'h0, 4'h4, F, 64'h0, 64'h0, 0, 64'h3, 64'h3, 4'h4, F, 4'h4, 4'h4));

        // Both write ports to r3: port M must win
        W_dstE = 4'h3; W_valE = 64'h5; W_dstM = 4'h3; W_valM = 64'h9;
        apply(mk("dual_wr", AOK, 4'h1, 4'h0, F, F, 64'h0, 64'h0, 0, 64'h0, 64'h0, F, F, F, F));
        W_dstE = F; W_dstM = F;
        apply(mk("dual_rd", AOK, 4'h2, 4'h0, 4'h3, 4'h1, 64'h0, 64'h0, 0, 64'h9, 64'h0, 4'h1, F, 4'h3, F));

        // Reset with a pending write: regfile cleared, write discarded
        @(negedge clk);
        W_dstE = 4'h5; W_valE = 64'hDEAD;
        rst_n = 1'b0;
        #1;
        chk("rst2.srcA", 64'(E_srcA), 64'(F));
        @(negedge clk);
        W_dstE = F;
        rst_n = 1'b1;
        apply(mk("rst_rd", AOK, 4'h4, 4'h0, 4'h3, 4'h5, 64'h0, 64'h0, 0, 64'h0, 64'h0, F, F, 4'h3, 4'h5));
        apply(mk("rst_rsp", AOK, 4'h9, 4'h0, F, F, 64'h0, 64'h0, 0, 64'h0, 64'h0, 4'h4, F, 4'h4, 4'h4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
